// File: rtl/dot_product_stream_engine.sv
// Multi-lane streaming dot-product engine: per-vector length, masked final beat, 3-stage datapath.
// Define DOT_SIGNED_EN to treat lanes as two's-complement; the default build is unsigned.
module dot_product_stream_engine #(
  parameter int DATA_WIDTH   = 8,
  parameter int LANES        = 4,
  parameter int MAX_LEN      = 64,
  parameter int LEN_WIDTH    = $clog2(MAX_LEN) + 1,
  parameter int RESULT_WIDTH = 2 * DATA_WIDTH + $clog2(MAX_LEN)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [LEN_WIDTH-1:0]          cfg_len,
  output logic                          busy,
  output logic                          err,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [LANES*DATA_WIDTH-1:0]   in_a,
  input  logic [LANES*DATA_WIDTH-1:0]   in_b,
  output logic                          res_valid,
  input  logic                          res_ready,
  output logic [RESULT_WIDTH-1:0]       res_data
);

  localparam int PROD_WIDTH = 2 * DATA_WIDTH;
  localparam int LANE_SHIFT = $clog2(LANES);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_HOLD} state_e;

  state_e                  state_q, state_d;
  logic [LEN_WIDTH-1:0]    len_q, len_d;
  logic [LEN_WIDTH-1:0]    beats_left_q, beats_left_d;
  logic                    busy_q, busy_d;
  logic                    in_ready_q, in_ready_d;
  logic                    res_valid_q, res_valid_d;
  logic                    err_q, err_d;

  // Stage 0: captured (masked) operands
  logic [DATA_WIDTH-1:0]   a_q [LANES];
  logic [DATA_WIDTH-1:0]   a_d [LANES];
  logic [DATA_WIDTH-1:0]   b_q [LANES];
  logic [DATA_WIDTH-1:0]   b_d [LANES];
  logic                    beat_vld_q, beat_vld_d, beat_last_q, beat_last_d;
  // Stage 1: extended lane products
  logic [RESULT_WIDTH-1:0] prod_q [LANES];
  logic [RESULT_WIDTH-1:0] prod_d [LANES];
  logic                    prod_vld_q, prod_vld_d, prod_last_q, prod_last_d;
  // Stage 2: reduced beat sum
  logic [RESULT_WIDTH-1:0] sum_q, sum_d;
  logic                    sum_vld_q, sum_vld_d, sum_last_q, sum_last_d;
  logic [RESULT_WIDTH-1:0] acc_q, acc_d;

`ifdef DOT_SIGNED_EN
  logic signed [PROD_WIDTH-1:0] lane_prod [LANES];
`else
  logic        [PROD_WIDTH-1:0] lane_prod [LANES];
`endif

  logic                    accept;
  logic                    last_beat;
  logic                    len_legal;
  logic [LEN_WIDTH-1:0]    rem;
  logic [LEN_WIDTH:0]      len_round;

  assign accept    = in_valid && in_ready_q;
  assign last_beat = accept && (beats_left_q == LEN_WIDTH'(1));
  assign len_legal = (cfg_len != '0) && (cfg_len <= LEN_WIDTH'(MAX_LEN));
  assign rem       = len_q & LEN_WIDTH'(LANES - 1);
  assign len_round = {1'b0, cfg_len} + (LEN_WIDTH + 1)'(LANES - 1);

  // Datapath: capture -> multiply -> reduce -> accumulate
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    a_d         = a_q;
    b_d         = b_q;
    beat_vld_d  = accept;
    beat_last_d = last_beat;
    prod_vld_d  = beat_vld_q;
    prod_last_d = beat_last_q;
    sum_vld_d   = prod_vld_q;
    sum_last_d  = prod_last_q;
    sum_d       = '0;

    if (accept) begin
      for (int i = 0; i < LANES; i++) begin
        // Zeroing a is enough to kill the product; b is don't-care then
        if (last_beat && (rem != '0) && (LEN_WIDTH'(i) >= rem)) a_d[i] = '0;
        else                                                    a_d[i] = in_a[i*DATA_WIDTH +: DATA_WIDTH];
        b_d[i] = in_b[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end

    for (int i = 0; i < LANES; i++) begin
`ifdef DOT_SIGNED_EN
      lane_prod[i] = PROD_WIDTH'($signed(a_q[i])) * PROD_WIDTH'($signed(b_q[i]));
      prod_d[i]    = {{(RESULT_WIDTH - PROD_WIDTH){lane_prod[i][PROD_WIDTH-1]}}, lane_prod[i]};
`else
      lane_prod[i] = PROD_WIDTH'(a_q[i]) * PROD_WIDTH'(b_q[i]);
      prod_d[i]    = RESULT_WIDTH'(lane_prod[i]);
`endif
    end

    for (int i = 0; i < LANES; i++) begin
      sum_d = sum_d + prod_q[i];
    end
  end

  // Control FSM and accumulator
  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    beats_left_d = beats_left_q;
    acc_d        = acc_q;
    err_d        = 1'b0;

    if (sum_vld_q) acc_d = acc_q + sum_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (len_legal) begin
            len_d        = cfg_len;
            beats_left_d = LEN_WIDTH'(len_round >> LANE_SHIFT);
            acc_d        = '0;
            state_d      = S_RUN;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_RUN: begin
        if (accept) begin
          beats_left_d = beats_left_q - LEN_WIDTH'(1);
          if (last_beat) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (sum_vld_q && sum_last_q) state_d = S_HOLD;
      end
      S_HOLD: begin
        if (res_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d      = (state_d != S_IDLE);
    in_ready_d  = (state_d == S_RUN);
    res_valid_d = (state_d == S_HOLD);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: state and datapath registers use non-blocking assignments so every flop samples pre-edge values.
      state_q      <= S_IDLE;
      len_q        <= '0;
      beats_left_q <= '0;
      busy_q       <= 1'b0;
      in_ready_q   <= 1'b0;
      res_valid_q  <= 1'b0;
      err_q        <= 1'b0;
      beat_vld_q   <= 1'b0;
      beat_last_q  <= 1'b0;
      prod_vld_q   <= 1'b0;
      prod_last_q  <= 1'b0;
      sum_q        <= '0;
      sum_vld_q    <= 1'b0;
      sum_last_q   <= 1'b0;
      acc_q        <= '0;
      for (int i = 0; i < LANES; i++) begin
        a_q[i]    <= '0;
        b_q[i]    <= '0;
        prod_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      beats_left_q <= beats_left_d;
      busy_q       <= busy_d;
      in_ready_q   <= in_ready_d;
      res_valid_q  <= res_valid_d;
      err_q        <= err_d;
      beat_vld_q   <= beat_vld_d;
      beat_last_q  <= beat_last_d;
      prod_vld_q   <= prod_vld_d;
      prod_last_q  <= prod_last_d;
      sum_q        <= sum_d;
      sum_vld_q    <= sum_vld_d;
      sum_last_q   <= sum_last_d;
      acc_q        <= acc_d;
      a_q          <= a_d;
      b_q          <= b_d;
      prod_q       <= prod_d;
    end
  end

  assign busy      = busy_q;
  assign err       = err_q;
  assign in_ready  = in_ready_q;
  assign res_valid = res_valid_q;
  assign res_data  = acc_q;

endmodule

// File: tb/tb_dot_product_stream_engine.sv
// Directed bench for dot_product_stream_engine (default parameters); expected values hand-computed.
// Build with DOT_SIGNED_EN defined to check the signed variant of the last vector.
module tb_dot_product_stream_engine;

  localparam int DW = 8;
  localparam int LN = 4;
  localparam int LW = 7;
  localparam int RW = 22;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [LW-1:0] cfg_len = '0;
  logic          busy, err;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [LN*DW-1:0] in_a = '0;
  logic [LN*DW-1:0] in_b = '0;
  logic          res_valid;
  logic          res_ready = 1'b0;
  logic [RW-1:0] res_data;

  int checks = 0;
  int errors = 0;

  dot_product_stream_engine dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .cfg_len   (cfg_len),
    .busy      (busy),
    .err       (err),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  function automatic logic [LN*DW-1:0] pk(input int l0, input int l1, input int l2, input int l3);
    return {8'(l3), 8'(l2), 8'(l1), 8'(l0)};
  endfunction

  task automatic do_start(input int len);
    start   = 1'b1;
    cfg_len = LW'(len);
    tick();
    start   = 1'b0;
  endtask

  task automatic send_beat(input string tag, input logic [LN*DW-1:0] a, input logic [LN*DW-1:0] b);
    int n = 0;
    logic done = 1'b0;
    in_a     = a;
    in_b     = b;
    in_valid = 1'b1;
    while (!done && n < 20) begin
      if (in_ready) done = 1'b1;
      tick();
      n++;
    end
    in_valid = 1'b0;
    check({tag, "_handshake"}, 32'(done), 1);
  endtask

  task automatic wait_result(input string tag);
    int n = 0;
    while (!res_valid && n < 50) begin
      tick();
      n++;
    end
    check({tag, "_res_valid"}, 32'(res_valid), 1);
  endtask

  task automatic consume(input string tag);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check({tag, "_valid_clear"}, 32'(res_valid), 0);
    check({tag, "_busy_clear"}, 32'(busy), 0);
  endtask

  initial begin
    int acc_cnt;
    int n;

    // Reset state
    tick();
    tick();
    check("rst_busy", 32'(busy), 0);
    check("rst_err", 32'(err), 0);
    check("rst_in_ready", 32'(in_ready), 0);
    check("rst_res_valid", 32'(res_valid), 0);
    check("rst_res_data", 32'(res_data), 0);
    rst = 1'b0;
    tick();

    // One full beat: 1+2+3+4 = 10, result 3 edges after the beat handshake
    do_start(4);
    check("v1_busy", 32'(busy), 1);
    check("v1_in_ready", 32'(in_ready), 1);
    send_beat("v1", pk(1, 2, 3, 4), pk(1, 1, 1, 1));
    check("v1_rv_k0", 32'(res_valid), 0);
    tick();
    tick();
    check("v1_rv_k2", 32'(res_valid), 0);
    tick();
    check("v1_rv_k3", 32'(res_valid), 1);
    check("v1_data", 32'(res_data), 10);
    consume("v1");

    // Length 6: 30 + 25 + 36 = 91, lanes 2,3 of beat 2 masked
    do_start(6);
    send_beat("v2b1", pk(1, 2, 3, 4), pk(1, 2, 3, 4));
    check("v2_ready_mid", 32'(in_ready), 1);
    send_beat("v2b2", pk(5, 6, 99, 99), pk(5, 6, 77, 77));
    check("v2_ready_after", 32'(in_ready), 0);
    wait_result("v2");
    check("v2_data", 32'(res_data), 91);
    consume("v2");

    // Max length with random valid gaps: 64 * 255 * 255 = 4161600
    do_start(64);
    in_a = pk(255, 255, 255, 255);
    in_b = pk(255, 255, 255, 255);
    acc_cnt = 0;
    n = 0;
    while (acc_cnt < 16 && n < 400) begin
      in_valid = 1'($urandom_range(0, 1));
      if (in_valid && in_ready) acc_cnt++;
      tick();
      n++;
    end
    check("v3_beats", 32'(acc_cnt), 16);
    in_valid = 1'b1;
    check("v3_ready_after", 32'(in_ready), 0);
    wait_result("v3");
    in_valid = 1'b0;
    check("v3_data", 32'(res_data), 4161600);
    consume("v3");

    // Back-pressure in HOLD with start pulsed: 2+4+6+8 = 20
    do_start(4);
    send_beat("v4", pk(1, 2, 3, 4), pk(2, 2, 2, 2));
    wait_result("v4");
    for (int i = 0; i < 5; i++) begin
      start   = 1'b1;
      cfg_len = LW'(4);
      tick();
      check("v4_hold_valid", 32'(res_valid), 1);
      check("v4_hold_data", 32'(res_data), 20);
      check("v4_hold_ready", 32'(in_ready), 0);
      check("v4_hold_err", 32'(err), 0);
    end
    start = 1'b0;
    consume("v4");
    // Start the cycle right after the result handshake: 3*3 = 9, lanes 1-3 masked
    do_start(1);
    check("v5_busy", 32'(busy), 1);
    send_beat("v5", pk(3, 7, 7, 7), pk(3, 7, 7, 7));
    wait_result("v5");
    check("v5_data", 32'(res_data), 9);
    consume("v5");

    // Illegal lengths
    do_start(0);
    check("len0_err", 32'(err), 1);
    check("len0_busy", 32'(busy), 0);
    tick();
    check("len0_err_pulse", 32'(err), 0);
    do_start(65);
    check("len65_err", 32'(err), 1);
    check("len65_busy", 32'(busy), 0);
    tick();
    check("len65_err_pulse", 32'(err), 0);

    // Reset mid-vector after 2 of 4 beats
    do_start(16);
    send_beat("abort_b1", pk(9, 9, 9, 9), pk(9, 9, 9, 9));
    send_beat("abort_b2", pk(9, 9, 9, 9), pk(9, 9, 9, 9));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_busy", 32'(busy), 0);
    check("abort_err", 32'(err), 0);
    check("abort_in_ready", 32'(in_ready), 0);
    check("abort_res_valid", 32'(res_valid), 0);
    check("abort_res_data", 32'(res_data), 0);
    repeat (6) tick();
    check("abort_no_result", 32'(res_valid), 0);
    do_start(4);
    send_beat("v6", pk(2, 2, 2, 2), pk(3, 3, 3, 3));
    wait_result("v6");
    check("v6_data", 32'(res_data), 24);
    consume("v6");

    // 0xFF * 0x02 with junk in masked lanes
    do_start(1);
    send_beat("v7", pk(255, 50, 60, 70), pk(2, 80, 90, 100));
    wait_result("v7");
`ifdef DOT_SIGNED_EN
    check("v7_data", 32'(res_data), 32'h003F_FFFE);
`else
    check("v7_data", 32'(res_data), 510);
`endif
    consume("v7");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dot_product_stream_engine.md
Name: dot_product_stream_engine

Overview:
Parametrised, pipelined, multi-lane dot-product engine. It accepts a runtime-configurable vector length and consumes LANES element pairs per beat over a valid/ready stream, typically fed by the memory read controller. Each product is multiplied, reduced through an adder tree and accumulated. One result per vector is returned on a valid/ready output with back-pressure. It supersedes the fixed-length 4-element dot product in the datapath.

Parameters:
DATA_WIDTH, 8, bit width of each element of a and b
LANES, 4, element pairs consumed per input beat (power of two, >=1)
MAX_LEN, 64, maximum vector length in elements
LEN_WIDTH, $clog2(MAX_LEN)+1, width of cfg_len
RESULT_WIDTH, 2*DATA_WIDTH+$clog2(MAX_LEN), accumulator/result width (overflow-free for MAX_LEN)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  begin a new vector; sampled only in IDLE
cfg_len  input  LEN_WIDTH  vector length in elements, latched on accepted start
busy  output  1  high in every state except IDLE
err  output  1  one-cycle pulse: start with cfg_len==0 or cfg_len>MAX_LEN
in_valid  input  1  input beat valid
in_ready  output  1  engine accepts beat (high only in RUN)
in_a  input  LANES*DATA_WIDTH  lane i = bits [i*DATA_WIDTH +: DATA_WIDTH]
in_b  input  LANES*DATA_WIDTH  same packing as in_a
res_valid  output  1  result available
res_ready  input  1  downstream accepts result
res_data  output  RESULT_WIDTH  dot-product result

Behaviour:
- Clocking/reset: one clock (clk). Reset is synchronous and active-high (rst). On rst: FSM to IDLE; busy, err, in_ready, res_valid = 0; res_data, accumulator and pipeline registers = 0. Reset mid-operation discards the partial sum. No res_valid appears for the aborted vector.
- FSM: IDLE -> RUN -> DRAIN -> HOLD -> IDLE.
- IDLE: start with a legal cfg_len latches the length, clears the accumulator and sets beats_left = ceil(cfg_len/LANES); next state is RUN. start with an illegal length pulses err for one cycle and stays in IDLE.
- start outside IDLE is ignored, with no err.
- RUN: in_ready = 1. A beat is accepted on in_valid && in_ready. Gaps in in_valid are allowed and add nothing. Accepting the final beat moves the FSM to DRAIN and drops in_ready in the next cycle.
- Final-beat masking: lanes i >= (cfg_len mod LANES) are forced to zero product when the remainder is non-zero. Unused lane data is don't-care.
- Pipeline: a beat accepted at edge k gives registered lane products at k+1, a registered adder-tree sum at k+2, and the accumulator updated at k+3.
- DRAIN: waits until the final beat's sum is accumulated, then moves to HOLD. res_valid is high from edge k+3, where k is the final-beat edge.
- HOLD: res_valid = 1 and res_data = accumulator. Both are held stable while res_ready = 0. On res_valid && res_ready the FSM returns to IDLE and res_valid clears at the next edge. The next start is accepted the cycle after that.
- Arithmetic: unsigned by default. Products are 2*DATA_WIDTH bits, zero-extended to RESULT_WIDTH before the tree. The sum cannot overflow for any length <= MAX_LEN.
- cfg_len == MAX_LEN is legal. cfg_len < LANES gives a single masked beat.

Optional Feature:
Macro DOT_SIGNED_EN.
- Defined: in_a and in_b lanes are two's-complement. Products are signed and sign-extended to RESULT_WIDTH, and res_data is two's-complement.
- Undefined: all operands are unsigned and zero-extended, as described in Behaviour.
- Masking, timing and the handshake are identical in both builds.

Test Plan:
- Defaults; cfg_len=4, one beat a=[1,2,3,4], b=[1,1,1,1] -> res_data=10; res_valid rises 3 cycles after the beat handshake; busy 0 after the res handshake.
- cfg_len=6; beat1 a=b=[1,2,3,4]; beat2 a=[5,6,99,99], b=[5,6,77,77] -> res_data=91 (lanes 2,3 masked); in_ready low after beat 2.
- cfg_len=64, 16 beats all 255 with random in_valid gaps -> res_data=4161600 (fits 22 bits); no extra beat accepted.
- res_ready held low 5 cycles in HOLD, start pulsed meanwhile -> res_data/res_valid stable, in_ready=0, start ignored; result consumed, new start next cycle works.
- start with cfg_len=0, then cfg_len=65 -> err one-cycle pulse each, busy stays 0. rst asserted after 2 of 4 beats -> all outputs 0; a new vector [2,2,2,2]·[3,3,3,3] -> 24.
- cfg_len=1, a0=8'hFF, b0=8'h02 -> with DOT_SIGNED_EN res_data=22'h3FFFFE (-2); without it res_data=510.
